// File: rtl/chunk_adder_pkg.sv
// chunk_adder_pkg -- shared types for the chunk-serial adder.
//   state_t : FSM encoding (IDLE waits for start, RUN adds one slice per
//             cycle, DONE presents the result for exactly one cycle).
package chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : chunk_adder_pkg

// File: rtl/chunk_adder_if.sv
// chunk_adder_if -- request/result bundle of the chunk-serial adder.
//   start, a, b, cin, sub : request side, driven by the master
//   busy, done, s, co, ovf: status/result side, driven by the adder (slave)
interface chunk_adder_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, s, co, ovf
    );
endinterface : chunk_adder_if

// File: rtl/chunk_adder_add.sv
// chunk_add -- combinational CHUNK-bit ripple slice.
//   a, b  : slice operands
//   ci    : carry into the slice LSB
//   sum   : slice sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (needed for signed overflow)
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] full_s;

    assign full_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign sum    = full_s[CHUNK-1:0];
    assign co     = full_s[CHUNK];
    // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign c_msb  = a[CHUNK-1] ^ b[CHUNK-1] ^ full_s[CHUNK-1];
endmodule : chunk_add

// File: rtl/chunk_adder.sv
// chunk_adder -- multi-cycle adder/subtractor, CHUNK bits per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : chunk_adder_if.slave
//           start/a/b/cin/sub in; busy (RUN), done (one-cycle pulse),
//           s (result), co (carry / no-borrow), ovf (signed overflow) out.
// An accepted start takes N = WIDTH/CHUNK RUN cycles, then one DONE cycle.
module chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    chunk_adder_if.slave  bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunk_adder: WIDTH must be an integer multiple of CHUNK");
    end

    state_t           state_r;
    state_t           state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             co_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic [CHUNK-1:0] slice_a_s;
    logic [CHUNK-1:0] slice_b_s;
    logic [CHUNK-1:0] slice_sum_s;
    logic             slice_co_s;
    logic             slice_cmsb_s;

    assign last_s    = (cnt_r == CNT_W'(N - 1));
    assign slice_a_s = a_r[cnt_r * CHUNK +: CHUNK];
    assign slice_b_s = b_r[cnt_r * CHUNK +: CHUNK];

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (slice_a_s),
        .b     (slice_b_s),
        .ci    (carry_r),
        .sum   (slice_sum_s),
        .co    (slice_co_s),
        .c_msb (slice_cmsb_s)
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nx = state_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                // start is deliberately not looked at here.
                step_s = 1'b1;
                if (last_s) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nx = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            busy_r  <= (state_nx == RUN);
            done_r  <= (state_nx == DONE);
        end
    end

    // Operand latch and slice-serial datapath. Subtraction is folded in at
    // accept time as a + ~b + 1, so no separate mode bit is carried along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            cnt_r   <= {CNT_W{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (step_s) begin
            s_r[cnt_r * CHUNK +: CHUNK] <= slice_sum_s;
            carry_r <= slice_co_s;
            if (last_s) begin
                cnt_r <= {CNT_W{1'b0}};
                co_r  <= slice_co_s;
                ovf_r <= slice_co_s ^ slice_cmsb_s;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.s    = s_r;
    assign bus.co   = co_r;
    assign bus.ovf  = ovf_r;
endmodule : chunk_adder

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder -- scoreboard bench for chunk_adder (WIDTH=12, CHUNK=4).
module tb_chunk_adder;
    localparam int WIDTH = 12;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;
    int   dc;
    exp_t exp_q[$];

    chunk_adder_if #(.WIDTH(WIDTH)) bus ();

    chunk_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 13-bit values.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH:0] full;
        exp_t           e;
        if (sub) begin
            full  = {1'b0, a} - {1'b0, b};
            e.s   = full[WIDTH-1:0];
            e.co  = ~full[WIDTH];
            e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
        end else begin
            full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            e.s   = full[WIDTH-1:0];
            e.co  = full[WIDTH];
            e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
        end
        return e;
    endfunction

    // Result checker: every done pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("s",   {20'd0, bus.s}, {20'd0, e.s});
                chk("co",  {31'd0, bus.co}, {31'd0, e.co});
                chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
            end
        end
    end

    // Issue one operation (called just after a negedge) and check busy/done
    // timing over the N RUN cycles and the DONE cycle. hold keeps start high
    // afterwards; ign drives an extra start with other operands during RUN.
    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input exp_t e,
                      input bit hold, input bit ign);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        exp_q.push_back(e);
        for (int m = 0; m <= N; m++) begin
            @(negedge clk);
            if (m == 0) begin
                if (ign) begin
                    bus.start = 1'b1;
                    bus.a     = 12'hFFF;
                    bus.b     = 12'hFFF;
                end else if (!hold) begin
                    bus.start = 1'b0;
                end
            end else if (m == 1 && ign) begin
                bus.start = 1'b0;
            end
            if (m < N) begin
                chk("busy_run", {31'd0, bus.busy}, 32'd1);
                chk("done_run", {31'd0, bus.done}, 32'd0);
            end else begin
                chk("busy_done", {31'd0, bus.busy}, 32'd0);
                chk("done_pulse", {31'd0, bus.done}, 32'd1);
            end
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_done", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_s"},    {20'd0, bus.s},    32'd0);
        chk({tag, "_co"},   {31'd0, bus.co},   32'd0);
        chk({tag, "_ovf"},  {31'd0, bus.ovf},  32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic             rs;
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 12'h000;
        bus.b     = 12'h000;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (2) @(negedge clk);
        zero_check("reset");
        rst_n = 1'b1;

        // First start right after reset release, then the directed vectors.
        e = '{s: 12'h000, co: 1'b1, ovf: 1'b0};
        op(12'hFFF, 12'h001, 1'b0, 1'b0, e, 1'b0, 1'b0);
        idle_check();
        e = '{s: 12'h800, co: 1'b0, ovf: 1'b1};
        op(12'h7FF, 12'h001, 1'b0, 1'b0, e, 1'b0, 1'b0);
        e = '{s: 12'hFFE, co: 1'b0, ovf: 1'b0};
        op(12'h005, 12'h007, 1'b1, 1'b1, e, 1'b0, 1'b0);
        e = '{s: 12'h002, co: 1'b1, ovf: 1'b0};
        op(12'h007, 12'h005, 1'b1, 1'b1, e, 1'b0, 1'b0);
        idle_check();

        // start during RUN must be ignored.
        dc = done_cnt;
        e  = '{s: 12'h234, co: 1'b0, ovf: 1'b0};
        op(12'h123, 12'h111, 1'b0, 1'b0, e, 1'b0, 1'b1);
        repeat (4) idle_check();
        chk("single_done", done_cnt - dc, 32'd1);

        // Reset after the second RUN edge aborts the operation.
        bus.a     = 12'h456;
        bus.b     = 12'h789;
        bus.cin   = 1'b1;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        zero_check("abort");
        exp_q.delete();
        dc = done_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("abort_done", {31'd0, bus.done}, 32'd0);
        end
        chk("abort_no_done", done_cnt - dc, 32'd0);
        rst_n = 1'b1;
        e = '{s: 12'h178, co: 1'b0, ovf: 1'b0};
        op(12'h0AB, 12'h0CD, 1'b0, 1'b0, e, 1'b0, 1'b0);
        idle_check();

        // start held high: back-to-back operations every N+1 cycles.
        for (int i = 0; i < 4; i++) begin
            ra = 12'(($urandom_range(0, 4095)));
            rb = 12'(($urandom_range(0, 4095)));
            rc = 1'(i);
            rs = 1'(i >> 1);
            op(ra, rb, rc, rs, model(ra, rb, rc, rs), (i < 3), 1'b0);
        end
        idle_check();

        // Random operations, including corner operands.
        for (int i = 0; i < 16; i++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 12'($urandom_range(0, 4095));
            if (i == 0) begin
                ra = 12'h800;
                rb = 12'h001;
            end
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            op(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0, 1'b0);
        end
        idle_check();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_chunk_adder
